lightbike_round_sequencer: RTL and testbench
============================================

# lightbike_round_sequencer

Match-level controller for the two-player lightbike game. Sits between the master switch, the bike boundary/trail-collision checks, the VGA trail-map clear logic and the processor's master enable. Sequences each round through map clear, countdown, play and result display, and keeps per-player scores until a match winner is declared. Its `run_en` output replaces the direct master-switch gating of the processor.

## Interface
Parameters:
- `TICK_DIV`, 10_000_000 — clock cycles per game tick (1 s at 10 MHz).
- `COUNT_TICKS`, 3 — countdown length in ticks; range 1..15.
- `HOLD_TICKS`, 2 — ticks the round result is held before advancing; range 1..15.
- `WIN_SCORE`, 5 — round wins needed to win the match; range 1..15.

Ports:
- `clock` in 1 — system clock; the only clock. All state changes on its rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `start` in 1 — master switch level; its rising edge starts or restarts a match.
- `enable` in 1 — pause control. Low freezes COUNT/RUN.
- `crash_one` in 1 — bike one out of bounds or on a trail; level.
- `crash_two` in 1 — same, for bike two.
- `clear_done` in 1 — map clear finished; level or pulse.
- `run_en` out 1 — processor master enable.
- `map_clear` out 1 — request to wipe the trail map; held until done.
- `countdown` out 4 — ticks remaining in the countdown; 0 otherwise.
- `score_one`, `score_two` out 4 each — round wins.
- `winner` out 2 — round result: 00 none, 01 bike one, 10 bike two, 11 draw.
- `match_over` out 1 — a player reached `WIN_SCORE`.
- `state` out 3 — debug encoding: IDLE=0, CLEAR=1, COUNT=2, RUN=3, ROUND_END=4, MATCH_END=5.

## Operation
- **Outputs:** all registered.
- **Start edge detect:** `start_q <= start`; `start_rise = start & ~start_q`.
- **Tick counter:** 0..`TICK_DIV`-1; `tick` asserts when the count equals `TICK_DIV`-1, then the counter wraps. The counter is zeroed on entry to COUNT and ROUND_END.
- **IDLE:** all outputs 0. On `start_rise` -> CLEAR.
- **CLEAR:** `map_clear`=1, `run_en`=0. When `clear_done` is sampled high -> COUNT with `countdown`=`COUNT_TICKS`, `winner`=00.
- **COUNT:** on each `tick` with `enable`=1, `countdown` decrements. A tick taken while `countdown`==1 -> RUN with `countdown`=0. Crashes are ignored.
- **RUN:** `run_en`=`enable`. Crash inputs are evaluated only when `enable`=1. The state exits on the first cycle either crash input is high:
  - both high -> `winner`=11, no score change;
  - `crash_one` only -> `winner`=10, `score_two`+1;
  - `crash_two` only -> `winner`=01, `score_one`+1;
  - then -> ROUND_END.
- **ROUND_END:** `run_en`=0. Holds for `HOLD_TICKS` ticks; `enable` is ignored here. Then:
  - if either score equals `WIN_SCORE` -> MATCH_END with `match_over`=1;
  - otherwise -> CLEAR.
- **MATCH_END:** outputs hold. On `start_rise`: scores and `winner` cleared, `match_over`=0, -> CLEAR.
- **Ignored inputs:** `start_rise` in CLEAR/COUNT/RUN/ROUND_END; `clear_done` outside CLEAR.
- **Scores:** saturate at `WIN_SCORE`; they never wrap.

## Timing
- **Reset:** state=IDLE, `start_q`=0, tick counter=0, every output 0. If `start` is high at reset release, `start_rise` fires on the first cycle after reset.
- **Reset mid-operation:** aborts any state next edge; scores are lost.
- **Crash latency:** a crash sampled at edge N gives `run_en`=0, updated `winner`/score and state=ROUND_END after edge N. That is one cycle of latency.
- **CLEAR -> COUNT:** `map_clear` drops on the edge that samples `clear_done`=1.
- **COUNT duration:** exactly `COUNT_TICKS`×`TICK_DIV` cycles with `enable` held high. Pause cycles extend it; the tick counter holds while `enable`=0.
- **ROUND_END duration:** exactly `HOLD_TICKS`×`TICK_DIV` cycles.
- **Pause in RUN:** `run_en` follows `enable` with one cycle of latency.

## Configuration
- **`LIGHTBIKE_COUNTDOWN_EN` defined:** COUNT state behaves as above.
- **`LIGHTBIKE_COUNTDOWN_EN` undefined:** CLEAR goes directly to RUN on `clear_done`; `countdown` is tied to 0; state code 2 is unreachable. `COUNT_TICKS` is ignored.

## Test plan
All scenarios use `TICK_DIV`=4, `COUNT_TICKS`=3, `HOLD_TICKS`=2, `WIN_SCORE`=2, with the macro defined unless stated.

1. **Reset and start:** reset 2 cycles, `start` 0->1, `clear_done` pulse 3 cycles later.
   - `map_clear`=1 from the cycle after `start_rise` until `clear_done`.
   - `countdown` 3,2,1, each for 4 cycles.
   - `run_en`=1 exactly 12 cycles after COUNT entry.
2. **Single crash:** `crash_one`=1 in RUN.
   - Next cycle: `run_en`=0, `winner`=10, `score_two`=1, state=4.
   - After 8 cycles: state=1.
3. **Draw:** `crash_one` and `crash_two` high on the same cycle -> `winner`=11, scores unchanged.
4. **Match win and restart:** bike two wins twice.
   - `match_over`=1, state=5; `start` toggling during play is ignored.
   - New `start_rise` -> scores 0, state=1.
5. **Pause:** `enable`=0 for 5 cycles mid-COUNT, then for 5 cycles in RUN with `crash_two` held high.
   - COUNT lasts 17 cycles.
   - Crash is ignored while paused; registered on the first enabled cycle.
6. **Reset mid-RUN:** state=0, all outputs 0 next cycle. Repeat scenario 1 with the macro undefined -> RUN directly after `clear_done`, `countdown` always 0.

Source files
------------

// File: rtl/lightbike_round_sequencer.sv
// Round/match sequencer for the two-player lightbike game.
// Define LIGHTBIKE_COUNTDOWN_EN to insert the COUNT state between CLEAR and RUN.
module lightbike_round_sequencer #(
  parameter int TICK_DIV    = 10_000_000,
  parameter int COUNT_TICKS = 3,
  parameter int HOLD_TICKS  = 2,
  parameter int WIN_SCORE   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       enable,
  input  logic       crash_one,
  input  logic       crash_two,
  input  logic       clear_done,
  output logic       run_en,
  output logic       map_clear,
  output logic [3:0] countdown,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic [1:0] winner,
  output logic       match_over,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_COUNT = 3'd2,
    S_RUN   = 3'd3,
    S_REND  = 3'd4,
    S_MEND  = 3'd5
  } state_t;

`ifdef LIGHTBIKE_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [3:0] CD_INIT   = 4'(COUNT_TICKS);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);
  localparam logic [3:0] WIN       = 4'(WIN_SCORE);

  state_t        state_q, state_d;
  logic          start_q;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    hold_q, hold_d;
  logic          run_en_q, run_en_d;
  logic          clr_q, clr_d;
  logic [3:0]    cd_q, cd_d;
  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [1:0]    win_q, win_d;
  logic          mo_q, mo_d;

  logic start_rise;
  logic tick;
  logic tcnt_run;

  assign start_rise = start & ~start_q;
  assign tick       = (tcnt_q == TICK_LAST);
  // Tick counter only advances where ticks matter; it freezes while paused.
  assign tcnt_run   = ((state_q == S_COUNT) && enable)
                    || (state_q == S_REND);

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    hold_d   = hold_q;
    run_en_d = run_en_q;
    clr_d    = clr_q;
    cd_d     = cd_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    win_d    = win_q;
    mo_d     = mo_q;

    if (tcnt_run) begin
      tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d = S_CLEAR;
          clr_d   = 1'b1;
        end
      end
      S_CLEAR: begin
        run_en_d = 1'b0;
        clr_d    = 1'b1;
        if (clear_done) begin
          clr_d  = 1'b0;
          win_d  = 2'b00;
          tcnt_d = '0;
          if (CD_EN) begin
            state_d = S_COUNT;
            cd_d    = CD_INIT;
          end else begin
            state_d  = S_RUN;
            run_en_d = enable;
          end
        end
      end
      S_COUNT: begin
        if (enable && tick) begin
          if (cd_q == 4'd1) begin
            state_d  = S_RUN;
            cd_d     = 4'd0;
            run_en_d = enable;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end
      end
      S_RUN: begin
        run_en_d = enable;
        if (enable && (crash_one || crash_two)) begin
          run_en_d = 1'b0;
          state_d  = S_REND;
          tcnt_d   = '0;
          hold_d   = 4'd0;
          if (crash_one && crash_two) begin
            win_d = 2'b11;
          end else if (crash_one) begin
            win_d = 2'b10;
            s2_d  = (s2_q < WIN) ? s2_q + 4'd1 : s2_q;
          end else begin
            win_d = 2'b01;
            s1_d  = (s1_q < WIN) ? s1_q + 4'd1 : s1_q;
          end
        end
      end
      S_REND: begin
        run_en_d = 1'b0;
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d = 4'd0;
            if ((s1_q == WIN) || (s2_q == WIN)) begin
              state_d = S_MEND;
              mo_d    = 1'b1;
            end else begin
              state_d = S_CLEAR;
              clr_d   = 1'b1;
            end
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
      end
      S_MEND: begin
        if (start_rise) begin
          s1_d    = 4'd0;
          s2_d    = 4'd0;
          win_d   = 2'b00;
          mo_d    = 1'b0;
          state_d = S_CLEAR;
          clr_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      tcnt_q   <= '0;
      hold_q   <= 4'd0;
      run_en_q <= 1'b0;
      clr_q    <= 1'b0;
      cd_q     <= 4'd0;
      s1_q     <= 4'd0;
      s2_q     <= 4'd0;
      win_q    <= 2'b00;
      mo_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      tcnt_q   <= tcnt_d;
      hold_q   <= hold_d;
      run_en_q <= run_en_d;
      clr_q    <= clr_d;
      cd_q     <= cd_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      win_q    <= win_d;
      mo_q     <= mo_d;
    end
  end

  assign run_en     = run_en_q;
  assign map_clear  = clr_q;
  assign countdown  = cd_q;
  assign score_one  = s1_q;
  assign score_two  = s2_q;
  assign winner     = win_q;
  assign match_over = mo_q;
  assign state      = state_q;

endmodule

// File: tb/tb_lightbike_round_sequencer.sv
// Directed bench for lightbike_round_sequencer (TICK_DIV=4, COUNT=3,
// HOLD=2, WIN=2); expectations follow the LIGHTBIKE_COUNTDOWN_EN build.
module tb_lightbike_round_sequencer;

  logic       clock = 1'b0;
  logic       reset, start, enable;
  logic       crash_one, crash_two, clear_done;
  logic       run_en, map_clear, match_over;
  logic [3:0] countdown, score_one, score_two;
  logic [1:0] winner;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

`ifdef LIGHTBIKE_COUNTDOWN_EN
  localparam int ST_AFT = 2;
  localparam int EN_AFT = 0;
  localparam int CD_AFT = 3;
`else
  localparam int ST_AFT = 3;
  localparam int EN_AFT = 1;
  localparam int CD_AFT = 0;
`endif

  always #5 clock = ~clock;

  lightbike_round_sequencer #(
    .TICK_DIV(4), .COUNT_TICKS(3), .HOLD_TICKS(2), .WIN_SCORE(2)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .enable(enable),
    .crash_one(crash_one), .crash_two(crash_two),
    .clear_done(clear_done), .run_en(run_en), .map_clear(map_clear),
    .countdown(countdown), .score_one(score_one),
    .score_two(score_two), .winner(winner),
    .match_over(match_over), .state(state)
  );

  typedef struct {
    logic rst;
    logic st;
    logic cd;
    int   e_state;
    int   e_map;
    int   e_run;
    int   e_cd;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".state"}, int'(state), 0);
    chk({tag, ".run_en"}, int'(run_en), 0);
    chk({tag, ".map_clear"}, int'(map_clear), 0);
    chk({tag, ".countdown"}, int'(countdown), 0);
    chk({tag, ".score_one"}, int'(score_one), 0);
    chk({tag, ".score_two"}, int'(score_two), 0);
    chk({tag, ".winner"}, int'(winner), 0);
    chk({tag, ".match_over"}, int'(match_over), 0);
  endtask

  task automatic count_to_run();
`ifdef LIGHTBIKE_COUNTDOWN_EN
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("count.cd", int'(countdown), (k == 12) ? 0 : 3 - k / 4);
      chk("count.run_en", int'(run_en), (k == 12) ? 1 : 0);
    end
`endif
    chk("run.state", int'(state), 3);
    chk("run.run_en", int'(run_en), 1);
    chk("run.cd", int'(countdown), 0);
  endtask

  task automatic clear_round();
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    chk("clr.state", int'(state), ST_AFT);
    chk("clr.map_clear", int'(map_clear), 0);
    count_to_run();
  endtask

  task automatic hold_wait(input int exp_state);
    step_n(7);
    chk("hold.state", int'(state), 4);
    step();
    chk("hold.next", int'(state), exp_state);
  endtask

  initial begin
    int n;
    tv[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 0, 0};
    tv[1] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 0};
    tv[3] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 0};
    tv[4] = '{1'b0, 1'b1, 1'b0, 1, 1, 0, 0};
    tv[5] = '{1'b0, 1'b1, 1'b1, ST_AFT, 0, EN_AFT, CD_AFT};

    reset = 1'b1; start = 1'b0; enable = 1'b1;
    crash_one = 1'b0; crash_two = 1'b0; clear_done = 1'b0;
    step_n(2);
    chk_zero("reset");

    for (int i = 0; i < 6; i++) begin
      reset = tv[i].rst;
      start = tv[i].st;
      clear_done = tv[i].cd;
      step();
      chk($sformatf("vec%0d.state", i), int'(state), tv[i].e_state);
      chk($sformatf("vec%0d.map", i), int'(map_clear), tv[i].e_map);
      chk($sformatf("vec%0d.run", i), int'(run_en), tv[i].e_run);
      chk($sformatf("vec%0d.cd", i), int'(countdown), tv[i].e_cd);
    end
    clear_done = 1'b0;
    count_to_run();

    // single crash: bike one out, bike two scores
    crash_one = 1'b1;
    step();
    crash_one = 1'b0;
    chk("crash.run_en", int'(run_en), 0);
    chk("crash.winner", int'(winner), 2);
    chk("crash.s2", int'(score_two), 1);
    chk("crash.s1", int'(score_one), 0);
    chk("crash.state", int'(state), 4);
    hold_wait(1);
    chk("crash.map_clear", int'(map_clear), 1);

    // draw
    clear_round();
    crash_one = 1'b1; crash_two = 1'b1;
    step();
    crash_one = 1'b0; crash_two = 1'b0;
    chk("draw.winner", int'(winner), 3);
    chk("draw.s1", int'(score_one), 0);
    chk("draw.s2", int'(score_two), 1);
    hold_wait(1);

    // bike two wins the match; start toggle in RUN ignored
    clear_round();
    start = 1'b0; step();
    start = 1'b1; step();
    chk("toggle.state", int'(state), 3);
    chk("toggle.run_en", int'(run_en), 1);
    crash_one = 1'b1;
    step();
    crash_one = 1'b0;
    chk("win.s2", int'(score_two), 2);
    chk("win.winner", int'(winner), 2);
    hold_wait(5);
    chk("mend.match_over", int'(match_over), 1);
    chk("mend.run_en", int'(run_en), 0);
    step_n(3);
    chk("mend.hold", int'(state), 5);
    chk("mend.s2", int'(score_two), 2);
    start = 1'b0; step();
    start = 1'b1; step();
    chk("restart.state", int'(state), 1);
    chk("restart.s2", int'(score_two), 0);
    chk("restart.winner", int'(winner), 0);
    chk("restart.mo", int'(match_over), 0);
    chk("restart.map", int'(map_clear), 1);

    // pause mid-COUNT
`ifdef LIGHTBIKE_COUNTDOWN_EN
    clear_done = 1'b1;
    step();
    clear_done = 1'b0;
    step_n(5);
    enable = 1'b0;
    step_n(5);
    enable = 1'b1;
    n = 10;
    while (state != 3'd3 && n < 40) begin
      step();
      n++;
    end
    chk("pause.count_len", n, 17);
    chk("pause.run_en", int'(run_en), 1);
`else
    clear_round();
`endif

    // pause in RUN with crash_two held
    enable = 1'b0;
    crash_two = 1'b1;
    step();
    chk("prun.run_en", int'(run_en), 0);
    step_n(4);
    chk("prun.state", int'(state), 3);
    chk("prun.winner", int'(winner), 0);
    enable = 1'b1;
    step();
    crash_two = 1'b0;
    chk("prun.crash_state", int'(state), 4);
    chk("prun.winner1", int'(winner), 1);
    chk("prun.s1", int'(score_one), 1);
    hold_wait(1);

    // reset mid-RUN, then start still high fires on release
    clear_round();
    reset = 1'b1;
    step();
    chk_zero("midreset");
    reset = 1'b0;
    step();
    chk("postreset.state", int'(state), 1);
    chk("postreset.map", int'(map_clear), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
